offset_skid_stage: RTL and testbench
====================================

OFFSET_SKID_STAGE -- requirements
Module: offset_skid_stage

Interface
REQ-001 SHALL have parameter OFFSET, default 2: signed 32-bit constant added to every accepted input word.
REQ-002 SHALL have parameter WIDTH, default 32: data width; fixed at 32 (int) in all instantiations.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream word present.
REQ-006 SHALL have port in_ready, output, 1: stage can accept a word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: signed input word.
REQ-008 SHALL have port out_valid, output, 1: output word present; drives the consumer's `a` input qualifier.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts this cycle.
REQ-010 SHALL have port out_data, output, WIDTH: signed result in_data + OFFSET.
REQ-011 SHALL have port xfer_count, output, 32: number of completed output transfers.

Function
REQ-012 SHALL register the transform: a word accepted at edge N appears on out_data with out_valid=1 after edge N (1-cycle latency) when the stage was empty.
REQ-013 SHALL use three states: EMPTY (no words), ONE (main register valid), TWO (main and skid registers valid).
REQ-014 SHALL drive in_ready=1 in EMPTY and ONE and 0 in TWO; in_ready SHALL be a register output, with no combinational path from out_ready.
REQ-015 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready.
REQ-016 SHALL apply these transitions: EMPTY+accept->ONE; ONE+accept&!emit->TWO (word to skid); ONE+emit&!accept->EMPTY; ONE+accept&emit->ONE (main reloaded); TWO+emit->ONE (skid moves to main); otherwise hold.
REQ-017 SHALL keep out_valid=1 exactly in ONE and TWO; out_data SHALL always be the main register.
REQ-018 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL preserve strict FIFO order; no word dropped or duplicated.
REQ-020 SHALL compute the addition modulo 2^32 (two's-complement wrap) unless REQ-027 applies.
REQ-021 SHALL increment xfer_count by 1 on every emit, wrapping 0xFFFFFFFF->0.
REQ-022 SHALL ignore in_data when in_valid=0; a word offered while in_ready=0 SHALL NOT be captured.
REQ-023 SHALL sustain one word per cycle when out_ready=1 continuously.

Reset
REQ-024 SHALL on rst=1 at an edge: state=EMPTY, out_valid=0, in_ready=1, out_data=0, skid register=0, xfer_count=0.
REQ-025 SHALL discard all buffered words on a reset asserted mid-operation, with no emit in that cycle counted; rst SHALL override accept and emit.

Configuration
REQ-026 SHALL gate saturation with macro OFFSET_SKID_STAGE_SAT_EN.
REQ-027 SHALL, when OFFSET_SKID_STAGE_SAT_EN is defined, clamp results to 32'h7FFFFFFF on positive overflow and 32'h80000000 on negative overflow; when undefined, wrap per REQ-020.

Verification
REQ-028 Reset, then in_data=40, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=42, xfer_count=1 after emit.
REQ-029 out_ready=0, offer 1, 2, 3 back-to-back -> 1 and 2 accepted, in_ready=0 with state TWO, 3 held; release out_ready -> outputs 3, 4, 5 in order, no loss.
REQ-030 in_data=32'h7FFFFFFF -> out_data=32'h80000001 without the macro; 32'h7FFFFFFF with the macro.
REQ-031 Stage in TWO, assert rst one cycle -> out_valid=0, in_ready=1, xfer_count=0 next cycle; old words never emitted.
REQ-032 in_valid=1 and out_ready=1 for 100 cycles with incrementing data -> 100 outputs, each equal to input+2, with one cycle of latency and no bubbles.

Source files
------------

// File: rtl/offset_skid_stage.sv
// Two-entry skid stage that adds a signed OFFSET to every accepted word; in_ready is registered.
// Optional saturation of the sum is enabled by defining OFFSET_SKID_STAGE_SAT_EN.
module offset_skid_stage #(
    parameter int OFFSET = 2,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      xfer_count
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = 32;
    localparam logic [W:0]  OFF_EXT = (W+1)'(OFFSET);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e         state_q;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [W:0]     sum_wide;
    logic [W-1:0]   sum_d;
    logic           accept_c;
    logic           emit_c;

    // One extra bit of headroom exposes signed overflow as a sign mismatch.
    always_comb begin
        sum_wide = {in_data[W-1], in_data} + OFF_EXT;
`ifdef OFFSET_SKID_STAGE_SAT_EN
        if (sum_wide[W] != sum_wide[W-1]) begin
            sum_d = sum_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_d = sum_wide[W-1:0];
        end
`else
        sum_d = sum_wide[W-1:0];
`endif
    end

    assign accept_c = in_valid & in_ready_q;
    assign emit_c   = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (emit_c) begin
                cnt_q <= cnt_q + CW'(1);
            end
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        main_q      <= sum_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept_c && !emit_c) begin
                        skid_q     <= sum_d;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (emit_c && !accept_c) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end else if (emit_c && accept_c) begin
                        main_q <= sum_d;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (emit_c) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_offset_skid_stage.sv
// Scoreboard bench for offset_skid_stage: expected words queued on accept, compared on emit.
// Define OFFSET_SKID_STAGE_SAT_EN here as well as in the RTL build to check the saturating variant.
module tb_offset_skid_stage;

    localparam int OFFSET_TB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] xfer_count;

    offset_skid_stage #(.OFFSET(OFFSET_TB), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_cnt = 32'h0;

    logic        obs_valid, obs_ready;
    logic [31:0] obs_data, obs_cnt;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_data, exp_cnt_now;

    function automatic logic [31:0] model(input logic [31:0] d);
        longint s;
        s = longint'($signed(d)) + longint'(OFFSET_TB);
`ifdef OFFSET_SKID_STAGE_SAT_EN
        if (s > longint'(32'h7FFFFFFF)) return 32'h7FFFFFFF;
        if (s < -longint'(32'h80000000)) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    // Drive one cycle, sample the DUT before the edge, then advance the model across it.
    task automatic step(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        in_valid = v;
        in_data = d;
        out_ready = r;
        #1;
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_data = out_data;
        obs_cnt = xfer_count;
        exp_valid = (sb.size() > 0);
        exp_ready = (sb.size() < 2);
        exp_data = exp_valid ? sb[0] : 32'h0;
        exp_cnt_now = exp_cnt;
        if (exp_valid && r) begin
            void'(sb.pop_front());
            exp_cnt = exp_cnt + 32'd1;
        end
        if (v && exp_ready) sb.push_back(model(d));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 32'h0;
        step(1'b0, 32'h0, 1'b0);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", obs_valid); end
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", obs_ready); end
        checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", obs_data); end
        checks++; if (obs_cnt !== 32'h0) begin errors++; $display("FAIL reset_xfer_count got %0d exp 0", obs_cnt); end
    endtask

    task automatic test_basic();
        step(1'b1, 32'd40, 1'b1);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %0b exp 0", obs_valid); end
        step(1'b0, 32'h0, 1'b1);
        checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", obs_valid); end
        checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL basic_data got %0d exp %0d", obs_data, exp_data); end
        checks++; if (obs_data !== 32'd42) begin errors++; $display("FAIL basic_data42 got %0d exp 42", obs_data); end
        step(1'b0, 32'h0, 1'b0);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0b exp 0", obs_valid); end
        checks++; if (obs_cnt !== 32'd1) begin errors++; $display("FAIL basic_xfer_count got %0d exp 1", obs_cnt); end
    endtask

    task automatic test_backpressure();
        logic        tv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] td[7] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd0, 32'd0};
        logic        tr[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(tv[i], td[i], tr[i]);
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL bp_valid[%0d] got %0b exp %0b", i, obs_valid, exp_valid); end
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL bp_ready[%0d] got %0b exp %0b", i, obs_ready, exp_ready); end
            if (exp_valid) begin
                checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, obs_data, exp_data); end
            end
            if (i == 2) begin
                checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", obs_ready); end
            end
        end
        checks++; if (obs_cnt !== exp_cnt_now) begin errors++; $display("FAIL bp_xfer_count got %0d exp %0d", obs_cnt, exp_cnt_now); end
    endtask

    task automatic test_wrap();
        logic [31:0] td[4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFE};
        logic [31:0] lit;
`ifdef OFFSET_SKID_STAGE_SAT_EN
        lit = 32'h7FFFFFFF;
`else
        lit = 32'h80000001;
`endif
        for (int i = 0; i < 5; i++) begin
            step(i < 4, (i < 4) ? td[i] : 32'h0, 1'b1);
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL wrap_valid[%0d] got %0b exp %0b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, obs_data, exp_data); end
            end
            if (i == 1) begin
                checks++; if (obs_data !== lit) begin errors++; $display("FAIL wrap_max got %h exp %h", obs_data, lit); end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'd100, 1'b0);
        step(1'b1, 32'd101, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks++; if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin errors++; $display("FAIL rmid_full got rdy %0b vld %0b exp rdy 0 vld 1", obs_ready, obs_valid); end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd55;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_cnt = 32'h0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b1);
            checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid[%0d] got %0b exp 0", i, obs_valid); end
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready[%0d] got %0b exp 1", i, obs_ready); end
            checks++; if (obs_cnt !== 32'h0) begin errors++; $display("FAIL rmid_xfer_count[%0d] got %0d exp 0", i, obs_cnt); end
            checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL rmid_data[%0d] got %0d exp 0", i, obs_data); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 100; i++) begin
            step(i < 100, 32'd1000 + 32'(i), 1'b1);
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0b exp 1", i, obs_ready); end
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp %0b", i, obs_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", i, obs_data, exp_data); end
            end
        end
        step(1'b0, 32'h0, 1'b1);
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b exp 0", obs_valid); end
        checks++; if (obs_cnt !== exp_cnt_now) begin errors++; $display("FAIL b2b_xfer_count got %0d exp %0d", obs_cnt, exp_cnt_now); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", i, obs_valid, exp_valid); end
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %0b exp %0b", i, obs_ready, exp_ready); end
            checks++; if (obs_cnt !== exp_cnt_now) begin errors++; $display("FAIL rnd_xfer_count[%0d] got %0d exp %0d", i, obs_cnt, exp_cnt_now); end
            if (exp_valid) begin
                checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, obs_data, exp_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
